// File: rtl/deserializer_pkg.sv
// rtl/deserializer_pkg.sv - constants and state type shared by the serial link blocks
package deserializer_pkg;

  localparam int DES_WIDTH    = 16;
  localparam int DES_W_INDEX  = $clog2(DES_WIDTH);
  localparam int DES_MIN_BITS = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

endpackage

// File: rtl/deserializer.sv
// rtl/deserializer.sv - rebuilds MSB-first valid-qualified serial bursts into left-aligned words
module deserializer
  import deserializer_pkg::*;
#(
  parameter int WIDTH    = DES_WIDTH,
  parameter int W_INDEX  = $clog2(WIDTH),
  parameter int MIN_BITS = DES_MIN_BITS
) (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic               ser_data_i,
  input  logic               ser_data_val_i,
  output logic [WIDTH-1:0]   deser_data_o,
  output logic [W_INDEX-1:0] deser_data_mod_o,
  output logic               deser_data_val_o,
  output logic               frame_err_o,
  output logic               busy_o
);

  state_e               state_q, state_d;
  logic [W_INDEX:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [W_INDEX-1:0]   mod_q, mod_d;
  logic                 val_q, val_d;
  logic                 err_q, err_d;
  logic [W_INDEX:0]     cnt_inc;
  logic [W_INDEX-1:0]   bit_idx;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    err_d   = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    bit_idx = W_INDEX'(WIDTH - 1) - cnt_q[W_INDEX-1:0];

    unique case (state_q)
      IDLE: begin
        if (ser_data_val_i) begin
          shift_d            = '0;
          shift_d[WIDTH-1]   = ser_data_i;
          cnt_d              = (W_INDEX+1)'(1);
          state_d            = RECV;
        end
      end
      RECV: begin
        if (ser_data_val_i) begin
          // cnt of 0 here means the previous word just filled; start fresh
          if (cnt_q == '0) begin
            shift_d = '0;
          end
          shift_d[bit_idx] = ser_data_i;
          cnt_d            = cnt_inc;
          if (cnt_inc == (W_INDEX+1)'(WIDTH)) begin
            data_d = shift_d;
            mod_d  = '0;
            val_d  = 1'b1;
            cnt_d  = '0;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          if (cnt_q >= (W_INDEX+1)'(MIN_BITS)) begin
            data_d = shift_q;
            mod_d  = cnt_q[W_INDEX-1:0];
            val_d  = 1'b1;
          end else if (cnt_q != '0) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    deser_data_o     = data_q;
    deser_data_mod_o = mod_q;
    deser_data_val_o = val_q;
    frame_err_o      = err_q;
    busy_o           = (state_q == RECV);
  end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed and serializer-style random checks for the deserializer
module tb_deserializer;

  localparam int WIDTH   = 16;
  localparam int W_INDEX = 4;

  logic               clk = 1'b0;
  logic               srst;
  logic               ser_data;
  logic               ser_val;
  logic [WIDTH-1:0]   deser_data;
  logic [W_INDEX-1:0] deser_mod;
  logic               deser_val;
  logic               frame_err;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [WIDTH-1:0]   q_data[$];
  logic [W_INDEX-1:0] q_mod[$];
  int                 q_cyc[$];
  logic               q_busy[$];
  int                 err_cnt  = 0;
  int                 both_cnt = 0;
  int                 last_bit_cyc;
  int                 base_idx;
  int                 base_err;

  deserializer dut (
    .clk_i            (clk),
    .srst_i           (srst),
    .ser_data_i       (ser_data),
    .ser_data_val_i   (ser_val),
    .deser_data_o     (deser_data),
    .deser_data_mod_o (deser_mod),
    .deser_data_val_o (deser_val),
    .frame_err_o      (frame_err),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (deser_val) begin
      q_data.push_back(deser_data);
      q_mod.push_back(deser_mod);
      q_cyc.push_back(cyc);
      q_busy.push_back(busy);
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (frame_err && deser_val) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b);
    @(posedge clk);
    #1;
    ser_val  = v;
    ser_data = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, bits[n-1-i]);
    last_bit_cyc = cyc;
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    send_bits(bits, n);
    idle(4);
  endtask

  task automatic mark;
    @(negedge clk);
    base_idx = q_data.size();
    base_err = err_cnt;
  endtask

  task automatic expect_word(input string tag, input int k, input logic [15:0] d, input logic [3:0] m);
    if (q_data.size() <= base_idx + k) begin
      check({tag, "_present"}, 32'(q_data.size() - base_idx), 32'(k + 1));
    end else begin
      check({tag, "_data"}, 32'(q_data[base_idx+k]), 32'(d));
      check({tag, "_mod"}, 32'(q_mod[base_idx+k]), 32'(m));
    end
  endtask

  initial begin
    logic [15:0] rd;
    int          m;
    int          nb;
    logic [15:0] mask;

    srst = 1'b1;
    ser_val = 1'b0;
    ser_data = 1'b0;
    idle(2);
    @(negedge clk);
    check("rst_data", 32'(deser_data), 32'h0);
    check("rst_mod", 32'(deser_mod), 32'h0);
    check("rst_val", 32'(deser_val), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    srst = 1'b0;
    idle(2);

    mark();
    send(32'hA5C3, 16);
    check("full_count", 32'(q_data.size() - base_idx), 32'd1);
    expect_word("full", 0, 16'hA5C3, 4'd0);
    if (q_cyc.size() > base_idx) check("full_lat", 32'(q_cyc[base_idx] - last_bit_cyc), 32'd1);
    check("full_err", 32'(err_cnt - base_err), 32'd0);

    mark();
    send(32'b10110, 5);
    check("short_count", 32'(q_data.size() - base_idx), 32'd1);
    expect_word("short", 0, 16'hB000, 4'd5);
    if (q_cyc.size() > base_idx) begin
      check("short_lat", 32'(q_cyc[base_idx] - last_bit_cyc), 32'd2);
      check("short_busy", 32'(q_busy[base_idx]), 32'd0);
    end

    mark();
    send(32'b11, 2);
    check("err_count", 32'(err_cnt - base_err), 32'd1);
    check("err_noval", 32'(q_data.size() - base_idx), 32'd0);
    check("err_hold_data", 32'(deser_data), 32'hB000);
    check("err_hold_mod", 32'(deser_mod), 32'd5);

    mark();
    send(32'b111, 3);
    expect_word("min3", 0, 16'hE000, 4'd3);
    check("min3_err", 32'(err_cnt - base_err), 32'd0);

    mark();
    send(32'hFFFF9, 20);
    check("split_count", 32'(q_data.size() - base_idx), 32'd2);
    expect_word("split0", 0, 16'hFFFF, 4'd0);
    expect_word("split1", 1, 16'h9000, 4'd4);
    if (q_busy.size() > base_idx) check("split_busy", 32'(q_busy[base_idx]), 32'd1);

    mark();
    send_bits(32'b1011001, 7);
    drive(1'b0, 1'b0);
    srst = 1'b1;
    idle(2);
    srst = 1'b0;
    idle(2);
    check("midrst_noval", 32'(q_data.size() - base_idx), 32'd0);
    check("midrst_noerr", 32'(err_cnt - base_err), 32'd0);
    send(32'b0111, 4);
    expect_word("after_rst", 0, 16'h7000, 4'd4);

    for (int t = 0; t < 24; t++) begin
      rd = 16'($urandom);
      m  = $urandom_range(3, 16);
      nb = m;
      mask = 16'hFFFF << (16 - nb);
      mark();
      send(32'(rd >> (16 - nb)), nb);
      expect_word("rand", 0, rd & mask, 4'(m));
    end

    check("val_err_overlap", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the team's serializer. Samples a serial bitstream qualified by a valid strobe, MSB first.
- Rebuilds each contiguous valid burst (one frame) into a left-aligned parallel word plus a bit-count code, using the same encoding the serializer takes on its input.
- Sits at the serial link sink. Output is a single-cycle strobe to downstream logic, with no backpressure.

Parameters:
- WIDTH, 16, parallel word width.
- W_INDEX, $clog2(WIDTH), width of the bit-count code.
- MIN_BITS, 3, shortest legal frame; shorter frames are errors.

Ports:
- clk_i  input  1  clock, all logic on rising edge
- srst_i  input  1  synchronous reset, active-high
- ser_data_i  input  1  serial data bit
- ser_data_val_i  input  1  ser_data_i is valid this cycle; contiguous high run = one frame
- deser_data_o  output  WIDTH  received word, first bit at [WIDTH-1], unfilled LSBs 0
- deser_data_mod_o  output  W_INDEX  bit count of the word; WIDTH encoded as 0
- deser_data_val_o  output  1  one-cycle strobe, deser_data_o/mod valid
- frame_err_o  output  1  one-cycle strobe, frame shorter than MIN_BITS discarded
- busy_o  output  1  frame in progress (state RECV)

Behaviour:
- Reset: all outputs 0, shift register 0, bit counter 0, state IDLE. Sampled every edge, overrides everything.
- Reset mid-frame: partial frame is discarded with no strobe; reception restarts clean on the next valid.
- FSM states: IDLE, RECV.
  - IDLE -> RECV on ser_data_val_i=1. That bit is stored at [WIDTH-1] and cnt becomes 1.
  - RECV with val=1: bit stored at position WIDTH-1-cnt; cnt increments.
  - RECV with val=0: frame ends. Go to IDLE and evaluate the frame.
- Full word:
  - On the edge sampling the WIDTH-th bit, register deser_data_o = assembled word, mod=0, val=1. The strobe is visible the cycle after the last bit.
  - cnt clears to 0 and the FSM stays in RECV.
  - If val is still 1 next cycle, that bit starts a new frame at [WIDTH-1] with no gap. Frames longer than WIDTH split into multiple words.
- Short end (val drops with 0<cnt<WIDTH):
  - If cnt >= MIN_BITS, on that edge register word (unfilled LSBs 0), mod=cnt, val=1. Latency is 2 cycles after the last bit.
  - If cnt < MIN_BITS, pulse frame_err_o=1 with no val strobe; deser_data_o/mod are unchanged.
- End with cnt=0 (val drops right after a full-word emit): no strobe, no error.
- Simultaneous events: deser_data_val_o and frame_err_o are never high together.
- Output holding: deser_data_o/mod hold their last value between strobes; val and err are high exactly one cycle per event.
- busy_o=1 iff state RECV. It is 0 in the cycle after a short end, and stays 1 across a full-word split while val is held.
- Shift register clears on each new frame start, so stale bits never leak into the LSBs.
- Widths:
  - cnt has W_INDEX+1 bits so it can hold WIDTH.
  - deser_data_mod_o = cnt[W_INDEX-1:0], so WIDTH wraps to 0.

Decomposition:
- Shared package (with the serializer): WIDTH, W_INDEX, MIN_BITS constants; state enum {IDLE, RECV}.
- Single module; no natural sub-module. Shift register, counter and FSM live together (~150 lines).

Test Plan:
- Reset check: hold srst_i 2 cycles -> all outputs 0, busy_o 0.
- Full word, end: 16 contiguous bits of 16'hA5C3 MSB first, then val low -> one strobe with data 16'hA5C3, mod 0, one cycle after the 16th bit. No further strobe and no err.
- Short frame: 5 bits 1,0,1,1,0 then val low -> data 16'hB000, mod 5, strobe 2 cycles after the last bit, busy_o low that cycle.
- Error and boundary:
  - 2 bits 1,1 -> frame_err_o one pulse, no val strobe, data/mod keep the previous values.
  - A 3-bit frame 1,1,1 -> data 16'hE000, mod 3.
- Split: 20 contiguous bits (16'hFFFF then 1,0,0,1) -> first strobe 16'hFFFF mod 0, then 16'h9000 mod 4. busy_o stays 1 between the two strobes.
- Reset mid-frame and random pass:
  - Assert srst_i after 7 bits -> no strobe. A following 4-bit frame 0,1,1,1 -> data 16'h7000, mod 4.
  - Loop the serializer driving this block with random data and random mod (skipping mod 1,2) -> every word and mod matches what was sent, masked to the transmitted bits.
